avaliador_equilibrio: RTL and testbench

AVALIADOR_EQUILIBRIO -- requirements
Module: avaliador_equilibrio

---
 rtl/avaliador_equilibrio_pkg.sv | 23 ++
 rtl/gerador_tick_ms.sv | 34 +++
 rtl/avaliador_equilibrio.sv | 145 ++++++++++++++
 tb/tb_avaliador_equilibrio.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/avaliador_equilibrio_pkg.sv
// Shared definitions for the balance-game evaluator.
// Contents: FSM state encoding, round-index width, and the helper that
// turns a clock frequency into the 1 ms prescaler divisor.
package avaliador_equilibrio_pkg;

    typedef enum logic [2:0] {
        OCIOSO    = 3'd0,
        SORTEIO   = 3'd1,
        BUSCANDO  = 3'd2,
        SEGURANDO = 3'd3,
        FIM       = 3'd4
    } estado_t;

    localparam int RODADA_W = 4;

    // Clock cycles per 1 ms tick; never below 1 so slow bench clocks still tick.
    function automatic int divisor_tick_ms(input int clk_freq_hz);
        int div;
        div = clk_freq_hz / 1000;
        return (div < 1) ? 1 : div;
    endfunction

endpackage

// File: rtl/gerador_tick_ms.sv
// 1 ms tick generator.
// Ports:
//   clock - system clock
//   reset - asynchronous active-high reset
//   tick  - one-cycle pulse every CLK_FREQ_HZ/1000 cycles (registered)
module gerador_tick_ms
    import avaliador_equilibrio_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50000000
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int DIV   = divisor_tick_ms(CLK_FREQ_HZ);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CNT_W'(DIV - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/avaliador_equilibrio.sv
// Balance-game evaluator: each round asks for a new target sector, then
// scores a hit if the pendulum stays in the sector for HOLD_MS, or ends the
// round on a ROUND_MS timeout. After NUM_RODADAS rounds the game stops in FIM.
// Ports:
//   clock, reset     - system clock, asynchronous active-high reset
//   iniciar          - start request (honoured in OCIOSO and FIM)
//   isInPosition     - pendulum in target sector (registered once internally)
//   nova_posicao     - one-cycle request for a new target (SORTEIO)
//   acerto           - one-cycle hit pulse
//   tempo_esgotado   - one-cycle round-timeout pulse
//   pontuacao        - saturating hit count
//   rodada           - current round index
//   jogo_ativo       - game in progress
//   fim_jogo         - game over
module avaliador_equilibrio
    import avaliador_equilibrio_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int HOLD_MS     = 1000,
    parameter int ROUND_MS    = 10000,
    parameter int NUM_RODADAS = 10,
    parameter int SCORE_W     = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic                isInPosition,
    output logic                nova_posicao,
    output logic                acerto,
    output logic                tempo_esgotado,
    output logic [SCORE_W-1:0]  pontuacao,
    output logic [RODADA_W-1:0] rodada,
    output logic                jogo_ativo,
    output logic                fim_jogo
);

    localparam int HOLD_W  = $clog2(HOLD_MS + 1);
    localparam int ROUND_W = $clog2(ROUND_MS + 1);

    estado_t             estado, prox_estado;
    logic                in_reg;
    logic                tick;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [ROUND_W-1:0]  round_q, round_d;
    logic [SCORE_W-1:0]  pont_d;
    logic [RODADA_W-1:0] rodada_d;
    logic                hold_fim, round_fim, ultima;

    gerador_tick_ms #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_tick (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

    // Timers end the round the moment they would reach their terminal value,
    // so they never exceed it.
    assign hold_fim  = tick && (hold_q + 1'b1 == HOLD_W'(HOLD_MS));
    assign round_fim = tick && (round_q + 1'b1 == ROUND_W'(ROUND_MS));
    assign ultima    = (rodada == RODADA_W'(NUM_RODADAS - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado    <= OCIOSO;
            in_reg    <= 1'b0;
            hold_q    <= '0;
            round_q   <= '0;
            pontuacao <= '0;
            rodada    <= '0;
        end else begin
            estado    <= prox_estado;
            in_reg    <= isInPosition;
            hold_q    <= hold_d;
            round_q   <= round_d;
            pontuacao <= pont_d;
            rodada    <= rodada_d;
        end
    end

    always_comb begin
        prox_estado    = estado;
        hold_d         = hold_q;
        round_d        = round_q;
        pont_d         = pontuacao;
        rodada_d       = rodada;
        acerto         = 1'b0;
        tempo_esgotado = 1'b0;

        unique case (estado)
            OCIOSO, FIM: begin
                if (iniciar) begin
                    pont_d      = '0;
                    rodada_d    = '0;
                    prox_estado = SORTEIO;
                end
            end
            // One settle cycle for the sector comparator after the new target.
            SORTEIO: begin
                hold_d      = '0;
                round_d     = '0;
                prox_estado = BUSCANDO;
            end
            BUSCANDO: begin
                if (tick) round_d = round_q + 1'b1;
                if (round_fim) begin
                    tempo_esgotado = 1'b1;
                end else if (in_reg) begin
                    hold_d      = '0;
                    prox_estado = SEGURANDO;
                end
            end
            SEGURANDO: begin
                if (tick) round_d = round_q + 1'b1;
                if (!in_reg) begin
                    hold_d = '0;
                    if (round_fim) tempo_esgotado = 1'b1;
                    else           prox_estado    = BUSCANDO;
                end else begin
                    if (tick) hold_d = hold_q + 1'b1;
                    // A hit on the same tick as the round expiry counts as a hit.
                    if (hold_fim) begin
                        acerto = 1'b1;
                        if (pontuacao != '1) pont_d = pontuacao + 1'b1;
                    end else if (round_fim) begin
                        tempo_esgotado = 1'b1;
                    end
                end
            end
            default: prox_estado = OCIOSO;
        endcase

        if (acerto || tempo_esgotado) begin
            if (ultima) begin
                prox_estado = FIM;
            end else begin
                rodada_d    = rodada + 1'b1;
                prox_estado = SORTEIO;
            end
        end
    end

    assign nova_posicao = (estado == SORTEIO);
    assign jogo_ativo   = (estado == SORTEIO) || (estado == BUSCANDO) || (estado == SEGURANDO);
    assign fim_jogo     = (estado == FIM);

endmodule

// File: tb/tb_avaliador_equilibrio.sv
// Scoreboard bench for avaliador_equilibrio. A round is described by the
// sequence of isInPosition samples driven from the nova_posicao cycle on;
// the reference model turns it into the expected outcome and cycle, which a
// separate monitor compares against the DUT pulses.
module tb_avaliador_equilibrio;

    localparam int CLK_FREQ_HZ = 1000;
    localparam int HOLD_MS     = 3;
    localparam int ROUND_MS    = 10;
    localparam int NUM_RODADAS = 2;
    localparam int SCORE_W     = 8;

    logic               clock = 1'b0;
    logic               reset;
    logic               iniciar;
    logic               isInPosition;
    logic               nova_posicao, acerto, tempo_esgotado, jogo_ativo, fim_jogo;
    logic [SCORE_W-1:0] pontuacao;
    logic [3:0]         rodada;

    avaliador_equilibrio #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .HOLD_MS     (HOLD_MS),
        .ROUND_MS    (ROUND_MS),
        .NUM_RODADAS (NUM_RODADAS),
        .SCORE_W     (SCORE_W)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .iniciar        (iniciar),
        .isInPosition   (isInPosition),
        .nova_posicao   (nova_posicao),
        .acerto         (acerto),
        .tempo_esgotado (tempo_esgotado),
        .pontuacao      (pontuacao),
        .rodada         (rodada),
        .jogo_ativo     (jogo_ativo),
        .fim_jogo       (fim_jogo)
    );

    always #5 clock = ~clock;

    typedef bit seq_t [ROUND_MS];
    typedef seq_t jogo_t [NUM_RODADAS];
    typedef struct { bit hit; int k; int score; int rod; } evento_t;

    evento_t esperado[$];
    int      n_chk = 0;
    int      n_ok  = 0;
    int      ciclo = 0;
    int      score_m = 0;

    task automatic check(input string nome, input int got, input int exp);
        n_chk++;
        if (got == exp) n_ok++;
        else $display("FAIL %s: got %0d expected %0d", nome, got, exp);
    endtask

    // Reference: the in-sector sample that starts the hold plus HOLD_MS more
    // consecutive in-sector samples (one per ms) make a hit; the round's
    // ROUND_MS-th ms ends it as a timeout unless that same ms completes a hit.
    // Sample c (1-based) is the value driven c-1 cycles after nova_posicao.
    function automatic void modelo(input seq_t seq, output bit hit, output int k);
        int seguidos;
        seguidos = 0;
        hit = 1'b0;
        k   = ROUND_MS;
        for (int c = 1; c <= ROUND_MS; c++) begin
            seguidos = seq[c-1] ? seguidos + 1 : 0;
            if (seguidos >= HOLD_MS + 1) begin
                hit = 1'b1;
                k   = c;
                return;
            end
        end
    endfunction

    // Monitor: cycle count since the last nova_posicao, pops on every pulse.
    initial begin
        evento_t e;
        forever begin
            @(negedge clock);
            if (nova_posicao) ciclo = 0;
            else              ciclo++;
            if (acerto || tempo_esgotado) begin
                if (esperado.size() == 0) begin
                    check("pulso_inesperado", {acerto, tempo_esgotado}, 0);
                end else begin
                    e = esperado.pop_front();
                    check("acerto", acerto, e.hit);
                    check("tempo_esgotado", tempo_esgotado, !e.hit);
                    check("ciclo_evento", ciclo, e.k);
                    check("pontuacao_evento", pontuacao, e.score);
                    check("rodada_evento", rodada, e.rod);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // which: 0 = nova_posicao, 1 = fim_jogo
    task automatic espera(input string nome, input int which);
        int n;
        n = 0;
        while (!(which == 0 ? nova_posicao : fim_jogo) && n < 30) begin
            @(negedge clock);
            n++;
        end
        check(nome, which == 0 ? nova_posicao : fim_jogo, 1);
    endtask

    // Called on the negedge where nova_posicao is seen.
    task automatic play_round(input seq_t seq, input int r);
        bit hit;
        int k;
        modelo(seq, hit, k);
        check("rodada_inicio", rodada, r);
        check("pontuacao_rodada", pontuacao, score_m);
        check("jogo_ativo", jogo_ativo, 1);
        esperado.push_back('{hit, k, score_m, r});
        if (hit) score_m = (score_m == 255) ? 255 : score_m + 1;
        for (int i = 0; i < k; i++) begin
            isInPosition = seq[i];
            @(negedge clock);
            if (i == 0) check("nova_posicao_unico", nova_posicao, 0);
        end
        isInPosition = 1'b0;
    endtask

    task automatic jogo(input jogo_t g);
        @(negedge clock);
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        score_m = 0;
        for (int r = 0; r < NUM_RODADAS; r++) begin
            espera("nova_posicao", 0);
            play_round(g[r], r);
        end
        espera("fim_jogo", 1);
        for (int i = 0; i < 3; i++) begin
            check("fim_jogo_nivel", fim_jogo, 1);
            check("fim_jogo_inativo", jogo_ativo, 0);
            check("fim_pontuacao", pontuacao, score_m);
            check("fim_rodada", rodada, NUM_RODADAS - 1);
            @(negedge clock);
        end
    endtask

    initial begin
        jogo_t g;
        reset        = 1'b1;
        iniciar      = 1'b0;
        isInPosition = 1'b0;
        #1;
        check("reset_saidas", {nova_posicao, acerto, tempo_esgotado, jogo_ativo,
                               fim_jogo, pontuacao, rodada}, 0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("ocioso_ativo", {jogo_ativo, fim_jogo, nova_posicao}, 0);

        // Held in sector; then 1,1,0,1,1,1,... pattern.
        for (int i = 0; i < ROUND_MS; i++) begin
            g[0][i] = 1'b1;
            g[1][i] = (i != 2);
        end
        jogo(g);

        // Timeout with score unchanged; then hold and round end on the same ms.
        for (int i = 0; i < ROUND_MS; i++) begin
            g[0][i] = 1'b0;
            g[1][i] = (i >= 6);
        end
        jogo(g);

        repeat (8) begin
            for (int r = 0; r < NUM_RODADAS; r++)
                for (int i = 0; i < ROUND_MS; i++)
                    g[r][i] = ($urandom_range(0, 4) != 0);
            jogo(g);
        end

        // Reset while holding in SEGURANDO.
        @(negedge clock);
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        espera("nova_posicao_reset", 0);
        isInPosition = 1'b1;
        repeat (2) @(negedge clock);
        check("segurando_ativo", jogo_ativo, 1);
        #1 reset = 1'b1;
        #1;
        check("reset_assinc", {nova_posicao, acerto, tempo_esgotado, jogo_ativo,
                               fim_jogo, pontuacao, rodada}, 0);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check("pos_reset", {nova_posicao, acerto, tempo_esgotado, jogo_ativo, fim_jogo}, 0);
        end
        check("fila_vazia", esperado.size(), 0);

        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end

endmodule
